// File: rtl/cache_miss_engine_pkg.sv
// rtl/cache_miss_engine_pkg.sv - shared widths, address slicing and FSM states for the cache miss engine
`define CACHE_OFFSET(a) a[3:2]
`define CACHE_INDEX(a)  a[4 +: includes::CACHE_INDEX_W]
`define CACHE_TAG(a)    a[31 -: includes::W_CTAG]

package includes;
    localparam int CACHE_INDEX_W  = 6;
    localparam int W_WORD         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int W_DATA         = W_WORD * WORDS_PER_LINE;
    localparam int W_CTAG         = 32 - 4 - CACHE_INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        INSTALL
    } state_e;
endpackage

// File: rtl/cache_miss_engine_line_word_merge.sv
// rtl/cache_miss_engine_line_word_merge.sv - replaces one 32-bit word of a cache line
module line_word_merge
    import includes::*;
(
    input  logic [W_DATA-1:0] line,
    input  logic [1:0]        offset,
    input  logic [W_WORD-1:0] word,
    output logic [W_DATA-1:0] merged
);

    always_comb begin
        merged = line;
        merged[offset * W_WORD +: W_WORD] = word;
    end

endmodule

// File: rtl/cache_miss_engine.sv
// rtl/cache_miss_engine.sv - cache control FSM: hit lookup, dirty write-back, 4-beat fill and install
module cache_miss_engine
    import includes::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_wdata,
    output logic                     cpu_ready,
    output logic [31:0]              cpu_rdata,
    output logic [CACHE_INDEX_W-1:0] set_index,
    output logic [W_CTAG-1:0]        set_ctag,
    output logic                     set_rd,
    output logic                     set_we,
    output logic                     set_wp,
    output logic                     set_wd,
    output logic [W_CTAG-1:0]        set_ctag_w,
    output logic [W_DATA-1:0]        set_data_w,
    input  logic                     set_hit,
    input  logic [W_DATA-1:0]        set_h_data,
    input  logic                     set_r_dirty,
    input  logic [W_CTAG-1:0]        set_r_ctag,
    input  logic [W_DATA-1:0]        set_r_data,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_ready,
    input  logic [31:0]              mem_rdata
);

    state_e            state;
    logic [1:0]        beat;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic              lat_we;
    logic [W_CTAG-1:0] vic_ctag;
    logic [W_DATA-1:0] vic_data;
    logic [W_DATA-1:0] line_buf;

    logic              idle;
    logic [31:0]       addr_sel;
    logic [1:0]        offset;
    logic [W_DATA-1:0] merge_line;
    logic [W_WORD-1:0] merge_word;
    logic [W_DATA-1:0] merged;
    logic              addr_unused;

    assign idle        = (state == IDLE);
    assign addr_sel    = idle ? cpu_addr : lat_addr;
    assign offset      = `CACHE_OFFSET(addr_sel);
    assign set_index   = `CACHE_INDEX(addr_sel);
    assign set_ctag    = `CACHE_TAG(addr_sel);
    assign addr_unused = ^addr_sel[1:0];

    // One merger serves both the write-hit path (IDLE) and the store-miss install.
    assign merge_line = idle ? set_h_data : line_buf;
    assign merge_word = idle ? cpu_wdata  : lat_wdata;

    line_word_merge u_merge (
        .line   (merge_line),
        .offset (offset),
        .word   (merge_word),
        .merged (merged)
    );

    assign cpu_rdata = merge_line[offset * W_WORD +: W_WORD];

    always_comb begin
        cpu_ready  = 1'b0;
        set_rd     = 1'b0;
        set_we     = 1'b0;
        set_wp     = 1'b0;
        set_wd     = 1'b0;
        set_ctag_w = set_ctag;
        set_data_w = merged;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = {addr_sel[31:4], beat, 2'b00};
        mem_wdata  = vic_data[beat * W_WORD +: W_WORD];
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (cpu_req && set_hit) begin
                        set_rd    = 1'b1;
                        cpu_ready = 1'b1;
                        if (cpu_we) begin
                            set_we = 1'b1;
                            set_wd = 1'b1;
                        end
                    end
                end
                WB: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = {vic_ctag, `CACHE_INDEX(addr_sel), beat, 2'b00};
                end
                FILL: begin
                    mem_req = 1'b1;
                end
                INSTALL: begin
                    set_we     = 1'b1;
                    set_wp     = 1'b1;
                    set_wd     = lat_we;
                    set_data_w = lat_we ? merged : line_buf;
                    cpu_ready  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= 2'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            vic_ctag  <= '0;
            vic_data  <= '0;
            line_buf  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req && !set_hit) begin
                        lat_addr  <= cpu_addr;
                        lat_wdata <= cpu_wdata;
                        lat_we    <= cpu_we;
                        vic_ctag  <= set_r_ctag;
                        vic_data  <= set_r_data;
                        beat      <= 2'd0;
                        state     <= set_r_dirty ? WB : FILL;
                    end
                end
                WB: begin
                    if (mem_ready) begin
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) state <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        line_buf[beat * W_WORD +: W_WORD] <= mem_rdata;
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) state <= INSTALL;
                    end
                end
                INSTALL: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_miss_engine.sv
// tb/tb_cache_miss_engine.sv - directed self-checking bench for cache_miss_engine
module tb_cache_miss_engine;
    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_we;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic [5:0]   set_index;
    logic [21:0]  set_ctag;
    logic         set_rd, set_we, set_wp, set_wd;
    logic [21:0]  set_ctag_w;
    logic [127:0] set_data_w;
    logic         set_hit;
    logic [127:0] set_h_data;
    logic         set_r_dirty;
    logic [21:0]  set_r_ctag;
    logic [127:0] set_r_data;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr, mem_wdata;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic [31:0]  mem_base;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory returns mem_base + word number of the requested beat.
    assign mem_rdata = mem_base + {30'd0, mem_addr[3:2]};

    cache_miss_engine dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .set_index(set_index), .set_ctag(set_ctag), .set_rd(set_rd),
        .set_we(set_we), .set_wp(set_wp), .set_wd(set_wd),
        .set_ctag_w(set_ctag_w), .set_data_w(set_data_w),
        .set_hit(set_hit), .set_h_data(set_h_data), .set_r_dirty(set_r_dirty),
        .set_r_ctag(set_r_ctag), .set_r_data(set_r_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    int beat_tab[7] = '{0, 1, 2, 2, 2, 2, 3};

    initial begin
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h48; cpu_wdata = '0;
        set_hit = 1'b1; set_h_data = '0; set_r_dirty = 1'b0; set_r_ctag = '0; set_r_data = '0;
        mem_ready = 1'b1; mem_base = '0;

        // Reset gates all strobes even with a hitting request present.
        tick(); tick(); sample();
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_set_rd", set_rd, 0);
        check("rst_set_we", set_we, 0);

        // Read hit, word 2.
        tick();
        rst = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0000_0048;
        set_h_data = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
        sample();
        check("rh_ready", cpu_ready, 1);
        check("rh_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("rh_set_rd", set_rd, 1);
        check("rh_set_we", set_we, 0);
        check("rh_mem_req", mem_req, 0);
        check("rh_index", set_index, 6'h04);

        // Write hit, word 1.
        tick();
        cpu_we = 1'b1; cpu_addr = 32'h0000_0044; cpu_wdata = 32'h1234_5678;
        sample();
        check("wh_ready", cpu_ready, 1);
        check("wh_we", set_we, 1);
        check("wh_wp", set_wp, 0);
        check("wh_wd", set_wd, 1);
        check("wh_ctag_w", set_ctag_w, 22'h0);
        check("wh_data_w", set_data_w,
              {32'h4444_4444, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1111_1111});

        // Clean read miss at 0x12340.
        tick();
        set_hit = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0001_2340; cpu_wdata = '0;
        set_r_dirty = 1'b0; mem_base = 32'hA0;
        sample();
        check("cm_t0_ready", cpu_ready, 0);
        check("cm_t0_mem_req", mem_req, 0);
        for (int b = 0; b < 4; b++) begin
            tick(); sample();
            check("cm_rd_req", mem_req, 1);
            check("cm_rd_we", mem_we, 0);
            check("cm_rd_addr", mem_addr, 32'h0001_2340 + 32'(4 * b));
            check("cm_rd_ready", cpu_ready, 0);
        end
        tick(); sample();
        check("cm_inst_ready", cpu_ready, 1);
        check("cm_inst_rdata", cpu_rdata, 32'hA0);
        check("cm_inst_we", set_we, 1);
        check("cm_inst_wp", set_wp, 1);
        check("cm_inst_wd", set_wd, 0);
        check("cm_inst_rd", set_rd, 0);
        check("cm_inst_ctag", set_ctag_w, 22'h48);
        check("cm_inst_index", set_index, 6'h34);
        check("cm_inst_data", set_data_w, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Dirty write miss: victim tag 3, index 0x34; store to tag 5 word 2.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_1748; cpu_wdata = 32'hCAFE_F00D;
        set_r_dirty = 1'b1; set_r_ctag = 22'h3; mem_base = 32'hC0;
        set_r_data = {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0};
        sample();
        check("dm_t0_ready", cpu_ready, 0);
        for (int b = 0; b < 4; b++) begin
            tick();
            if (b == 0) begin
                set_r_dirty = 1'b0; set_r_ctag = '0; set_r_data = '0;
            end
            sample();
            check("dm_wb_req", mem_req, 1);
            check("dm_wb_we", mem_we, 1);
            check("dm_wb_addr", mem_addr, 32'h0000_0F40 + 32'(4 * b));
            check("dm_wb_data", mem_wdata, {4{8'hB0 + 8'(b)}});
        end
        for (int b = 0; b < 4; b++) begin
            tick(); sample();
            check("dm_fill_we", mem_we, 0);
            check("dm_fill_addr", mem_addr, 32'h0000_1740 + 32'(4 * b));
            check("dm_fill_ready", cpu_ready, 0);
        end
        tick(); sample();
        check("dm_inst_ready", cpu_ready, 1);
        check("dm_inst_wd", set_wd, 1);
        check("dm_inst_wp", set_wp, 1);
        check("dm_inst_ctag", set_ctag_w, 22'h5);
        check("dm_inst_data", set_data_w, {32'hC3, 32'hCAFE_F00D, 32'hC1, 32'hC0});

        // Clean read miss with mem_ready low for three cycles on fill beat 2.
        tick();
        cpu_we = 1'b0; cpu_addr = 32'h0000_0B1C; mem_base = 32'hD0;
        sample();
        for (int c = 1; c <= 7; c++) begin
            tick();
            mem_ready = !(c >= 3 && c <= 5);
            sample();
            check("st_addr", mem_addr, 32'h0000_0B10 + 32'(4 * beat_tab[c-1]));
            check("st_req", mem_req, 1);
            check("st_ready_low", cpu_ready, 0);
        end
        tick(); mem_ready = 1'b1; sample();
        check("st_inst_ready", cpu_ready, 1);
        check("st_inst_rdata", cpu_rdata, 32'hD3);
        check("st_inst_data", set_data_w, {32'hD3, 32'hD2, 32'hD1, 32'hD0});

        // Reset pulsed during write-back beat 2.
        tick();
        cpu_we = 1'b1; cpu_addr = 32'h0000_1748; set_r_dirty = 1'b1; set_r_ctag = 22'h3;
        for (int c = 1; c <= 2; c++) begin
            tick(); sample();
            check("rb_wb_req", mem_req, 1);
        end
        tick(); rst = 1'b1; sample();
        check("rb_rst_mem_req", mem_req, 0);
        check("rb_rst_set_we", set_we, 0);
        check("rb_rst_ready", cpu_ready, 0);
        tick(); rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0000_0048;
        set_r_dirty = 1'b0; sample();
        check("rb_idle_mem_req", mem_req, 0);
        check("rb_idle_index", set_index, 6'h04);
        for (int c = 0; c < 2; c++) begin
            tick(); sample();
            check("rb_no_install", set_we, 0);
        end
        tick(); cpu_req = 1'b1; set_hit = 1'b1; sample();
        check("rb_hit_ready", cpu_ready, 1);
        check("rb_hit_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("rb_hit_mem_req", mem_req, 0);
        tick(); cpu_req = 1'b0; set_hit = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
